// File: rtl/jtag_tap_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_tap_sequencer
// On-chip JTAG master. Turns TAP-reset / IR-scan / DR-scan / idle-clock
// commands into TCK/TMS/TDI waveforms and captures TDO into a response word.
// The target TAP is assumed to sit in RUN_TEST_IDLE between commands; after
// reset the sequencer only knows it is in TEST_LOGIC_RESET and inserts one
// TMS=0 clock before the first scan/idle command.
//
// Ports
//   clk, rst          system clock, synchronous active-low reset
//   cmd_valid/ready   command handshake: a command is taken on a clk edge
//                     where cmd_valid && cmd_ready; cmd_type/length/data are
//                     latched on that edge and cmd_ready drops the next cycle.
//                     cmd_ready returns in the same cycle as rsp_valid.
//   cmd_type          00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks
//   cmd_length        scan bits / idle TCKs; 0 acts as 1, clamps at MAX_LENGTH
//   cmd_data          TDI bits, shifted LSB first
//   rsp_valid         one-clk pulse when a command completes
//   rsp_data          captured TDO (bit i = i-th shifted bit), held until the
//                     next completion
//   busy              command in progress
//   jtag_tck/tms/tdi  JTAG outputs (registered)
//   jtag_tdo          TDO from the target
// -----------------------------------------------------------------------------
module jtag_tap_sequencer #(
  parameter int CLOCK_DIV  = 4,
  parameter int MAX_LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [5:0]            cmd_length,
  input  logic [MAX_LENGTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [MAX_LENGTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  jtag_tck,
  output logic                  jtag_tms,
  output logic                  jtag_tdi,
  input  logic                  jtag_tdo
);

  localparam int DIV_W = $clog2(2 * CLOCK_DIV);
  localparam int IDX_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLOCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLOCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [5:0]       MAX_LEN6 = 6'(MAX_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_IDLE, S_RESET, S_NAV_IN, S_SHIFT, S_NAV_OUT, S_WAIT, S_DONE
  } state_t;

  // Only two target states are ever known to the sequencer.
  typedef enum logic {TAP_TLR, TAP_RTI} tap_t;

  state_t                state_q, state_d, start_st, nxt_st;
  tap_t                  tap_q, tap_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [5:0]            cnt_q, cnt_d, len_q, len_d, eff_len, nxt_cnt;
  logic [1:0]            type_q, type_d;
  logic [MAX_LENGTH-1:0] data_q, data_d, shift_q, shift_d, rsp_data_q, rsp_data_d;
  logic                  tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d, is_ir;

  // Number of TCKs spent in each segment of a command.
  function automatic logic [5:0] seg_len(state_t st, logic ir, logic [5:0] n);
    case (st)
      S_PRE_IDLE: seg_len = 6'd1;
      S_RESET:    seg_len = 6'd6;
      S_NAV_IN:   seg_len = ir ? 6'd4 : 6'd3;
      S_SHIFT:    seg_len = n;
      S_NAV_OUT:  seg_len = 6'd2;
      S_WAIT:     seg_len = n;
      default:    seg_len = 6'd1;
    endcase
  endfunction

  // TMS value for TCK number c of a segment.
  function automatic logic seg_tms(state_t st, logic [5:0] c, logic ir, logic [5:0] n);
    case (st)
      S_PRE_IDLE: seg_tms = 1'b0;
      S_RESET:    seg_tms = (c < 6'd5);
      S_NAV_IN:   seg_tms = ir ? (c < 6'd2) : (c == 6'd0);
      S_SHIFT:    seg_tms = (c == n - 6'd1);  // last bit moves to Exit1
      S_NAV_OUT:  seg_tms = (c == 6'd0);
      S_WAIT:     seg_tms = 1'b0;
      default:    seg_tms = 1'b1;
    endcase
  endfunction

  function automatic state_t seg_next(state_t st, logic [1:0] t);
    case (st)
      S_PRE_IDLE: seg_next = (t == 2'b11) ? S_WAIT : S_NAV_IN;
      S_NAV_IN:   seg_next = S_SHIFT;
      S_SHIFT:    seg_next = S_NAV_OUT;
      default:    seg_next = S_DONE;
    endcase
  endfunction

  function automatic state_t first_seg(logic [1:0] t, tap_t tap);
    if (t == 2'b00)       first_seg = S_RESET;
    else if (tap != TAP_RTI) first_seg = S_PRE_IDLE;
    else if (t == 2'b11)  first_seg = S_WAIT;
    else                  first_seg = S_NAV_IN;
  endfunction

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    type_d      = type_q;
    data_d      = data_q;
    shift_d     = shift_q;
    rsp_data_d  = rsp_data_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    nxt_st      = state_q;
    nxt_cnt     = cnt_q;
    is_ir       = (type_q == 2'b01);

    if (cmd_length == 6'd0)         eff_len = 6'd1;
    else if (cmd_length > MAX_LEN6) eff_len = MAX_LEN6;
    else                            eff_len = cmd_length;
    start_st = first_seg(cmd_type, tap_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = start_st;
          type_d      = cmd_type;
          len_d       = eff_len;
          data_d      = cmd_data;
          shift_d     = '0;
          div_d       = '0;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          // TCK is already low: the first bit's TMS goes out on this edge.
          tms_d       = seg_tms(start_st, 6'd0, cmd_type == 2'b01, eff_len);
          tdi_d       = 1'b0;
        end
      end
      default: begin
        if (div_q == DIV_RISE) begin
          tck_d = 1'b1;
          div_d = div_q + DIV_ONE;
          if (state_q == S_SHIFT) shift_d[cnt_q[IDX_W-1:0]] = jtag_tdo;
        end else if (div_q == DIV_LAST) begin
          tck_d = 1'b0;
          div_d = '0;
          if ({1'b0, cnt_q} + 7'd1 < {1'b0, seg_len(state_q, is_ir, len_q)}) begin
            nxt_cnt = cnt_q + 6'd1;
          end else begin
            nxt_st  = seg_next(state_q, type_q);
            nxt_cnt = '0;
          end
          state_d = nxt_st;
          cnt_d   = nxt_cnt;
          if (nxt_st == S_DONE) begin
            tdi_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_q;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            tap_d       = TAP_RTI;
          end else begin
            tms_d = seg_tms(nxt_st, nxt_cnt, is_ir, len_q);
            tdi_d = (nxt_st == S_SHIFT) ? data_q[nxt_cnt[IDX_W-1:0]] : 1'b0;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tap_q       <= TAP_TLR;
      div_q       <= '0;
      cnt_q       <= '0;
      len_q       <= 6'd1;
      type_q      <= 2'b00;
      data_q      <= '0;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      type_q      <= type_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      rsp_data_q  <= rsp_data_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_sequencer
// Drives jtag_tap_sequencer into a behavioural target TAP (5-bit IR, IDCODE
// and BYPASS data registers). Expected responses come from a bit-stream view
// of each scan (captured register followed by the shifted-in data); expected
// TMS/TDI sequences are built from the command rules.
// -----------------------------------------------------------------------------
module tb_jtag_tap_sequencer;

  localparam logic [31:0] IDCODE_VAL = {4'h1, 16'hBEEF, 11'h0A5, 1'b1};
  localparam logic [4:0]  IDC_INS    = 5'b00100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [5:0]  cmd_length = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

  jtag_tap_sequencer #(.CLOCK_DIV(4), .MAX_LENGTH(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  // ---------------- behavioural target TAP ----------------
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;
  int          tap_st = TLR;
  logic [4:0]  t_ir = IDC_INS;
  logic [4:0]  t_ir_sr = 5'd0;
  logic [31:0] t_dr_sr = 32'd0;

  assign jtag_tdo = (tap_st == SHDR) ? t_dr_sr[0] : (tap_st == SHIR) ? t_ir_sr[0] : 1'b0;

  always @(posedge jtag_tck) begin
    case (tap_st)
      TLR:   t_ir <= IDC_INS;
      CAPIR: t_ir_sr <= t_ir;
      SHIR:  t_ir_sr <= {jtag_tdi, t_ir_sr[4:1]};
      UPIR:  t_ir <= t_ir_sr;
      CAPDR: t_dr_sr <= (t_ir == IDC_INS) ? IDCODE_VAL : 32'd0;
      SHDR:  if (t_ir == IDC_INS) t_dr_sr <= {jtag_tdi, t_dr_sr[31:1]};
             else t_dr_sr <= {31'd0, jtag_tdi};
      default: ;
    endcase
    case (tap_st)
      TLR:   tap_st <= jtag_tms ? TLR : RTI;
      RTI:   tap_st <= jtag_tms ? SELDR : RTI;
      SELDR: tap_st <= jtag_tms ? SELIR : CAPDR;
      CAPDR: tap_st <= jtag_tms ? EX1DR : SHDR;
      SHDR:  tap_st <= jtag_tms ? EX1DR : SHDR;
      EX1DR: tap_st <= jtag_tms ? UPDR : PDR;
      PDR:   tap_st <= jtag_tms ? EX2DR : PDR;
      EX2DR: tap_st <= jtag_tms ? UPDR : SHDR;
      UPDR:  tap_st <= jtag_tms ? SELDR : RTI;
      SELIR: tap_st <= jtag_tms ? TLR : CAPIR;
      CAPIR: tap_st <= jtag_tms ? EX1IR : SHIR;
      SHIR:  tap_st <= jtag_tms ? EX1IR : SHIR;
      EX1IR: tap_st <= jtag_tms ? UPIR : PIR;
      PIR:   tap_st <= jtag_tms ? EX2IR : PIR;
      EX2IR: tap_st <= jtag_tms ? UPIR : SHIR;
      default: tap_st <= jtag_tms ? SELDR : RTI;
    endcase
  end

  // ---------------- monitors ----------------
  logic [1:0] got_q[$];   // {tms,tdi} at each TCK rise
  logic [1:0] exp_q[$];
  int rsp_cnt = 0;
  int exp_pulses = 0;

  always @(posedge jtag_tck) got_q.push_back({jtag_tms, jtag_tdi});
  always @(negedge clk) if (rsp_valid) rsp_cnt++;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_seq(input string name);
    int err;
    err = -1;
    if (got_q.size() != exp_q.size()) err = 999;
    else for (int i = 0; i < exp_q.size(); i++) if (err < 0 && got_q[i] !== exp_q[i]) err = i;
    total++;
    if (err >= 0) begin
      bad++;
      $display("FAIL %s tms_tdi_seq first_bad=%0d got_len=%0d exp_len=%0d", name, err,
               got_q.size(), exp_q.size());
    end
  endtask

  // ---------------- reference model ----------------
  bit         model_tlr = 1'b1;
  logic [4:0] model_ir = IDC_INS;

  function automatic int eff_len(input logic [5:0] l);
    if (l == 6'd0) return 1;
    if (l > 6'd32) return 32;
    return int'(l);
  endfunction

  function automatic int tck_count(input logic [1:0] t, input logic [5:0] l, input bit tlr);
    int pre;
    pre = (t != 2'b00 && tlr) ? 1 : 0;
    case (t)
      2'b00:   return 6;
      2'b01:   return pre + eff_len(l) + 6;
      2'b10:   return pre + eff_len(l) + 5;
      default: return pre + eff_len(l);
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d, input bit tlr);
    int n;
    n = eff_len(l);
    if (t != 2'b00 && tlr) exp_q.push_back(2'b00);
    case (t)
      2'b00: begin
        for (int k = 0; k < 5; k++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
      2'b11: for (int k = 0; k < n; k++) exp_q.push_back(2'b00);
      default: begin
        exp_q.push_back(2'b10);
        if (t == 2'b01) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, d[k]});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
    endcase
  endtask

  // Scan = stream of (captured register bits, then TDI bits); TDO sees the
  // first n stream bits, the IR keeps the 5 bits following them.
  task automatic predict(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                         output logic [31:0] r);
    int n;
    logic s[$];
    n = eff_len(l);
    r = 32'd0;
    if (t == 2'b00) model_ir = IDC_INS;
    if (t == 2'b01) for (int k = 0; k < 5; k++) s.push_back(model_ir[k]);
    if (t == 2'b10) begin
      if (model_ir == IDC_INS) for (int k = 0; k < 32; k++) s.push_back(IDCODE_VAL[k]);
      else s.push_back(1'b0);
    end
    if (t == 2'b01 || t == 2'b10) begin
      for (int k = 0; k < n; k++) s.push_back(d[k]);
      for (int k = 0; k < n; k++) r[k] = s[k];
      if (t == 2'b01) for (int k = 0; k < 5; k++) model_ir[k] = s[n + k];
    end
    model_tlr = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic wait_rsp(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 6000);
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL %s rsp_timeout got=none exp=pulse", name);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] t, input logic [5:0] l,
                         input logic [31:0] d, input int exp_tck, input logic [31:0] exp_rsp,
                         input bit tlr);
    int cyc, guard;
    exp_q.delete();
    got_q.delete();
    build_exp(t, l, d, tlr);
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    check({name, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_type = t; cmd_length = l; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_pulses++;
    check({name, "_accept_busy_ready"}, 32'({busy, cmd_ready}), 32'b10);
    wait_rsp(name, cyc);
    check({name, "_clks"}, 32'(cyc), 32'(8 * exp_tck));
    check({name, "_rsp_data"}, rsp_data, exp_rsp);
    check({name, "_tck_count"}, 32'(got_q.size()), 32'(exp_tck));
    check_seq(name);
    check({name, "_done_busy_ready"}, 32'({busy, cmd_ready}), 32'b01);
    @(posedge clk); #1;
    check({name, "_pulse_len"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  len;
    logic [31:0] data;
    int          exp_tck;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] r, r1, r2;
    logic [1:0]  t;
    logic [5:0]  l;
    logic [31:0] d;
    bit          tlr0;
    int          cyc, guard, base;

    vecs[0]  = '{2'b01, 6'd5,  32'h1F,       12, 32'h04};
    vecs[1]  = '{2'b01, 6'd5,  32'h04,       11, 32'h1F};
    vecs[2]  = '{2'b10, 6'd32, 32'h0,        37, IDCODE_VAL};
    vecs[3]  = '{2'b01, 6'd5,  32'h1F,       11, 32'h04};
    vecs[4]  = '{2'b10, 6'd1,  32'h1,         6, 32'h0};
    vecs[5]  = '{2'b10, 6'd0,  32'h1,         6, 32'h0};
    vecs[6]  = '{2'b00, 6'd0,  32'h0,         6, 32'h0};
    vecs[7]  = '{2'b10, 6'd40, 32'hFFFFFFFF, 37, IDCODE_VAL};
    vecs[8]  = '{2'b11, 6'd3,  32'h0,         3, 32'h0};
    vecs[9]  = '{2'b10, 6'd8,  32'hA5,       13, 32'h4B};
    vecs[10] = '{2'b01, 6'd8,  32'hF8,       14, 32'h04};
    vecs[11] = '{2'b10, 6'd4,  32'hB,         9, 32'h6};
    vecs[12] = '{2'b11, 6'd0,  32'h0,         1, 32'h0};
    vecs[13] = '{2'b01, 6'd5,  32'h04,       11, 32'h1F};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", 32'(jtag_tck), 32'd0);
    check("rst_tms", 32'(jtag_tms), 32'd1);
    check("rst_tdi", 32'(jtag_tdi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      tlr0 = model_tlr;
      predict(vecs[i].t, vecs[i].len, vecs[i].data, r);
      run_cmd($sformatf("vec%0d", i), vecs[i].t, vecs[i].len, vecs[i].data,
              vecs[i].exp_tck, vecs[i].exp_rsp, tlr0);
    end

    // back-to-back: cmd_valid held across the completion of an idle command
    exp_q.delete();
    got_q.delete();
    build_exp(2'b11, 6'd3, 32'd0, model_tlr);
    predict(2'b11, 6'd3, 32'd0, r1);
    build_exp(2'b10, 6'd8, 32'h3C, model_tlr);
    predict(2'b10, 6'd8, 32'h3C, r2);
    @(negedge clk);
    cmd_type = 2'b11; cmd_length = 6'd3; cmd_data = 32'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    exp_pulses++;
    check("b2b_accept1", 32'({busy, cmd_ready}), 32'b10);
    cmd_type = 2'b10; cmd_length = 6'd8; cmd_data = 32'h3C;
    wait_rsp("b2b_first", cyc);
    check("b2b_clks1", 32'(cyc), 32'd24);
    check("b2b_rsp1", rsp_data, r1);
    check("b2b_ready1", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_pulses++;
    check("b2b_accept2", 32'({busy, cmd_ready, rsp_valid}), 32'b100);
    wait_rsp("b2b_second", cyc);
    check("b2b_clks2", 32'(cyc), 32'd104);
    check("b2b_rsp2", rsp_data, r2);
    check_seq("b2b");
    @(posedge clk); #1;
    check("b2b_pulse_len", 32'(rsp_valid), 32'd0);

    // reset in the middle of a DR scan
    got_q.delete();
    @(negedge clk);
    cmd_type = 2'b10; cmd_length = 6'd32; cmd_data = $urandom; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 10 && guard < 1000) begin @(posedge clk); #1; guard++; end
    check("mid_tck_rises", 32'(got_q.size()), 32'd10);
    @(negedge clk);
    rst = 1'b0;
    base = rsp_cnt;
    @(posedge clk); #1;
    check("mid_rst_outputs", 32'({jtag_tck, jtag_tms, busy, rsp_valid, cmd_ready}), 32'b01001);
    @(negedge clk);
    rst = 1'b1;
    model_tlr = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_rsp", 32'(rsp_cnt), 32'(base));
    tlr0 = model_tlr;
    predict(2'b00, 6'd0, 32'd0, r);
    run_cmd("post_rst_reset", 2'b00, 6'd0, 32'd0, 6, r, tlr0);

    // randomized commands against the model
    for (int i = 0; i < 25; i++) begin
      t = 2'($urandom_range(0, 3));
      l = 6'($urandom_range(0, 40));
      d = $urandom;
      tlr0 = model_tlr;
      predict(t, l, d, r);
      run_cmd($sformatf("rnd%0d", i), t, l, d, tck_count(t, l, tlr0), r, tlr0);
    end

    repeat (4) @(negedge clk);
    check("rsp_pulse_total", 32'(rsp_cnt), 32'(exp_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
